// File: rtl/line_window_buffer.sv
// Raster-scan pixel stream to 3x3 sliding window converter (valid padding).
// Two line buffers feed the top/mid taps; the newest pixel feeds the bottom tap.
module line_window_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic signed [7:0] pix_data,
  output logic              win_valid_out,
  input  logic              win_ready,
  output logic signed [7:0] data_out0,
  output logic signed [7:0] data_out1,
  output logic signed [7:0] data_out2,
  output logic signed [7:0] data_out3,
  output logic signed [7:0] data_out4,
  output logic signed [7:0] data_out5,
  output logic signed [7:0] data_out6,
  output logic signed [7:0] data_out7,
  output logic signed [7:0] data_out8,
  output logic              frame_done,
  output logic              dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_e;

  state_e            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic              win_valid_q;
  logic              frame_done_q;
  logic signed [7:0] win_q   [9];
  logic signed [7:0] line0_q [IMG_W];
  logic signed [7:0] line1_q [IMG_W];

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              emit;
  logic signed [7:0] tap_top;
  logic signed [7:0] tap_mid;

  // Handshake: a pixel transfers when pix_valid && pix_ready; a window transfers
  // when win_valid_out && win_ready. A held window stalls the input (no skid).
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign emit      = accept && (state_q == STREAM) && (col_q >= CW'(2));
  assign tap_top   = line0_q[col_q];
  assign tap_mid   = line1_q[col_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      frame_done_q <= accept && col_last && row_last;
      if (emit)
        win_valid_q <= 1'b1;
      else if (win_ready)
        win_valid_q <= 1'b0;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win_q[3*i]   <= win_q[3*i+1];
          win_q[3*i+1] <= win_q[3*i+2];
        end
        win_q[2] <= tap_top;
        win_q[5] <= tap_mid;
        win_q[8] <= pix_data;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        // STREAM covers rows 2..IMG_H-1, where every column >= 2 yields a window.
        case (state_q)
          FILL:    if (col_last && row_q == RW'(1)) state_q <= STREAM;
          STREAM:  if (col_last && row_last)        state_q <= FILL;
          default: state_q <= FILL;
        endcase
      end
    end
  end

  // Line buffers are always written before read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0_q[col_q] <= tap_mid;
      line1_q[col_q] <= pix_data;
    end
  end

  assign win_valid_out = win_valid_q;
  assign frame_done    = frame_done_q;
  assign dbg_state     = (state_q == STREAM);
  assign data_out0     = win_q[0];
  assign data_out1     = win_q[1];
  assign data_out2     = win_q[2];
  assign data_out3     = win_q[3];
  assign data_out4     = win_q[4];
  assign data_out5     = win_q[5];
  assign data_out6     = win_q[6];
  assign data_out7     = win_q[7];
  assign data_out8     = win_q[8];

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer on a 5x4 image: directed window table,
// backpressure/reset sequences and random gaps against an image-array model.
module tb_line_window_buffer;

  localparam int W = 5;
  localparam int H = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic              pix_ready;
  logic signed [7:0] pix_data;
  logic              win_valid_out;
  logic              win_ready;
  logic signed [7:0] d [9];
  logic              frame_done;
  logic              dbg_state;

  line_window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .win_valid_out(win_valid_out), .win_ready(win_ready),
    .data_out0(d[0]), .data_out1(d[1]), .data_out2(d[2]), .data_out3(d[3]),
    .data_out4(d[4]), .data_out5(d[5]), .data_out6(d[6]), .data_out7(d[7]),
    .data_out8(d[8]), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          row;
    int          col;
    logic [71:0] win;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q [$];
  logic [71:0] got_q [$];
  logic [7:0]  img [H][W];
  int          m_row, m_col, fd_count;
  bit          fd_pend, emit_pend, hold_pend;
  logic [71:0] hold_win;
  vec_t        tbl [6];

  function automatic logic [71:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
  endfunction

  function automatic logic [71:0] cur_win();
    return {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7], d[8]};
  endfunction

  // Reference window: the 3x3 block of the stored image ending at (r,c).
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], img[r-2+i][c-2+j]};
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    exp_q.delete();
    fd_pend = 0; emit_pend = 0; hold_pend = 0;
  endtask

  // One clock: drive at negedge, observe 1 time unit before the rising edge.
  task automatic cycle(input bit v, input logic [7:0] px, input bit rdy, output bit acc);
    bit out_hs;
    pix_valid = v; pix_data = px; win_ready = rdy;
    #4;
    chk("pix_ready", 72'(pix_ready), 72'(!win_valid_out || win_ready));
    chk("frame_done", 72'(frame_done), 72'(fd_pend));
    if (frame_done) fd_count++;
    if (emit_pend) chk("win_latency", 72'(win_valid_out), 72'(1));
    if (hold_pend) begin
      chk("hold_valid", 72'(win_valid_out), 72'(1));
      chk("hold_data", cur_win(), hold_win);
    end
    acc    = v && pix_ready;
    out_hs = win_valid_out && win_ready;
    if (out_hs) begin
      got_q.push_back(cur_win());
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_window got %h expected none", cur_win());
      end else begin
        chk("window", cur_win(), exp_q.pop_front());
      end
    end
    hold_pend = win_valid_out && !win_ready;
    hold_win  = cur_win();
    emit_pend = 0; fd_pend = 0;
    if (acc) begin
      img[m_row][m_col] = px;
      if (m_row >= 2 && m_col >= 2) begin
        exp_q.push_back(model_win(m_row, m_col));
        emit_pend = 1;
      end
      fd_pend = (m_row == H - 1) && (m_col == W - 1);
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input int n, input int start, input int pv_pct, input int rdy_pct);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < n && guard < 2000) begin
      cycle($urandom_range(0, 99) < pv_pct, 8'(start + k), $urandom_range(0, 99) < rdy_pct, acc);
      if (acc) k++;
      guard++;
    end
    if (k < n) begin
      checks++; errors++;
      $display("FAIL feed_timeout got %0d accepted expected %0d", k, n);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd0, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst = 1; pix_valid = 0; win_ready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_win_valid", 72'(win_valid_out), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_pix_ready", 72'(pix_ready), 72'(1));
    chk("rst_data", cur_win(), 72'(0));
    chk("rst_state", 72'(dbg_state), 72'(0));
    rst = 0;
    model_reset();
  endtask

  task automatic check_table(input string tag, input int base);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(6));
    for (int i = 0; i < 6; i++)
      chk({tag, "_", tbl[i].name}, (i < got_q.size()) ? got_q[i] : 72'bx,
          tbl[i].win + {9{8'(base)}});
  endtask

  initial begin
    bit acc;
    tbl[0] = '{"w22", 2, 2, w9(0, 1, 2, 5, 6, 7, 10, 11, 12)};
    tbl[1] = '{"w23", 2, 3, w9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
    tbl[2] = '{"w24", 2, 4, w9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
    tbl[3] = '{"w32", 3, 2, w9(5, 6, 7, 10, 11, 12, 15, 16, 17)};
    tbl[4] = '{"w33", 3, 3, w9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
    tbl[5] = '{"w34", 3, 4, w9(7, 8, 9, 12, 13, 14, 17, 18, 19)};
    rst = 1; pix_valid = 0; pix_data = 0; win_ready = 1;
    @(negedge clk);
    do_reset();

    // Fill: no window through 12 pixels; 13th produces the first window.
    fd_count = 0; got_q.delete();
    feed(12, 0, 100, 100);
    chk("fill_no_window", 72'(got_q.size()), 72'(0));
    chk("fill_valid_low", 72'(win_valid_out), 72'(0));
    chk("fill_state", 72'(dbg_state), 72'(1));
    feed(1, 12, 100, 100);
    cycle(1'b0, 8'd0, 1'b1, acc);
    chk("first_window", (got_q.size() > 0) ? got_q[0] : 72'bx, tbl[0].win);
    feed(7, 13, 100, 100);
    drain();

    // Full frame, continuous.
    fd_count = 0; got_q.delete();
    feed(20, 0, 100, 100);
    drain();
    check_table("full", 0);
    chk("full_frame_done", 72'(fd_count), 72'(1));

    // Backpressure on the first window for 3 cycles.
    fd_count = 0; got_q.delete();
    feed(13, 0, 100, 100);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'd13, 1'b0, acc);
      chk("bp_no_accept", 72'(acc), 72'(0));
    end
    feed(7, 13, 100, 100);
    drain();
    check_table("bp", 0);
    chk("bp_frame_done", 72'(fd_count), 72'(1));

    // Random pixel gaps and random downstream readiness.
    fd_count = 0; got_q.delete();
    feed(20, 0, 50, 50);
    drain();
    check_table("rand", 0);
    chk("rand_frame_done", 72'(fd_count), 72'(1));

    // Two back-to-back frames.
    fd_count = 0; got_q.delete();
    feed(20, 0, 100, 100);
    feed(20, 100, 100, 100);
    drain();
    chk("b2b_count", 72'(got_q.size()), 72'(12));
    chk("b2b_second_first", (got_q.size() > 6) ? got_q[6] : 72'bx,
        w9(100, 101, 102, 105, 106, 107, 110, 111, 112));
    chk("b2b_frame_done", 72'(fd_count), 72'(2));

    // Reset with a window pending, then restart.
    feed(14, 0, 100, 100);
    chk("pending_before_rst", 72'(win_valid_out), 72'(1));
    do_reset();
    fd_count = 0; got_q.delete();
    feed(12, 0, 100, 100);
    chk("rst_refill_none", 72'(got_q.size()), 72'(0));
    feed(1, 12, 100, 100);
    drain();
    chk("rst_first_window", (got_q.size() > 0) ? got_q[0] : 72'bx, tbl[0].win);
    chk("rst_one_window", 72'(got_q.size()), 72'(1));

    // Random-value frames against the image model.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < W * H; k++) begin
        logic [7:0] v = 8'($urandom_range(0, 255));
        int guard = 0;
        acc = 0;
        while (!acc && guard < 200) begin
          cycle($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) != 0, acc);
          guard++;
        end
      end
    end
    drain();
    chk("final_queue_empty", 72'(exp_q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
